// File: rtl/axi_timed_buffer_prog.sv
// Purpose: FIFO that holds each beat for a programmable minimum latency before offering it downstream.
// Latency: a beat pushed with lat_cfg = L is offered in the cycle after edge push+min(L,MAX_LAT).
// Backpressure: ready_out = not full (state only); valid_out is registered state, no pass-through.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   flush           - synchronous drop of all entries (beats handshaked this cycle are lost)
//   lat_cfg         - latency for the beat accepted this cycle, saturated to MAX_LAT
//   valid_in/data_in/ready_out   - upstream channel
//   valid_out/data_out/ready_in  - downstream channel
//   occupancy       - number of stored entries
module axi_timed_buffer_prog #(
  parameter int DATA_WIDTH   = 64,
  parameter int BUFFER_DEPTH = 4,
  parameter int MAX_LAT      = 15,
  localparam int LAT_W       = $clog2(MAX_LAT + 1),
  localparam int OCC_W       = $clog2(BUFFER_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [LAT_W-1:0]      lat_cfg,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ready_out,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic [OCC_W-1:0]      occupancy
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam logic [LAT_W-1:0] MAX_LAT_L = LAT_W'(MAX_LAT);
  localparam logic [LAT_W-1:0] LAT_ONE   = LAT_W'(1);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(BUFFER_DEPTH - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(BUFFER_DEPTH);
  localparam logic [OCC_W-1:0] OCC_ONE   = OCC_W'(1);

  logic [DATA_WIDTH-1:0] storage_q [BUFFER_DEPTH];
  logic [LAT_W-1:0]      cnt_q     [BUFFER_DEPTH];
  logic [LAT_W-1:0]      cnt_d     [BUFFER_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0]      elements_q, elements_d;

  logic             push;
  logic             pop;
  logic [LAT_W-1:0] lat_sat;

  assign ready_out = (elements_q != OCC_FULL);
  assign valid_out = (elements_q != '0) && (cnt_q[rd_ptr_q] == '0);
  assign data_out  = storage_q[rd_ptr_q];
  assign occupancy = elements_q;

  assign push    = valid_in && ready_out;
  assign pop     = valid_out && ready_in;
  assign lat_sat = (lat_cfg > MAX_LAT_L) ? MAX_LAT_L : lat_cfg;

  always_comb begin
    // All nonzero counters age every cycle, head or not, so a younger beat
    // can already be expired by the time it reaches the head.
    for (int i = 0; i < BUFFER_DEPTH; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? (cnt_q[i] - LAT_ONE) : cnt_q[i];
    end
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    elements_d = elements_q;

    if (flush) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        cnt_d[i] = '0;
      end
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      elements_d = '0;
    end else begin
      if (push) begin
        // Fresh load overrides the decrement of the same cycle.
        cnt_d[wr_ptr_q] = lat_sat;
        wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : (wr_ptr_q + PTR_ONE);
      end
      if (pop) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : (rd_ptr_q + PTR_ONE);
      end
      case ({push, pop})
        2'b10:   elements_d = elements_q + OCC_ONE;
        2'b01:   elements_d = elements_q - OCC_ONE;
        default: elements_d = elements_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        storage_q[i] <= '0;
        cnt_q[i]     <= '0;
      end
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      elements_q <= '0;
    end else begin
      for (int i = 0; i < BUFFER_DEPTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      if (push && !flush) begin
        storage_q[wr_ptr_q] <= data_in;
      end
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      elements_q <= elements_d;
    end
  end

  a_elements_bound: assert property (@(posedge clk) disable iff (rst)
    elements_q <= OCC_FULL);
  a_empty_no_valid: assert property (@(posedge clk) disable iff (rst)
    (elements_q == '0) |-> !valid_out);
  a_no_push_full: assert property (@(posedge clk) disable iff (rst)
    !(valid_in && ready_out && (elements_q == OCC_FULL)));

endmodule
